// File: rtl/ava_pkg.sv
// ============================================================
// ava_pkg : line-state, error-code and FSM definitions for ava_rx
// Rev 1.0
// ============================================================
`default_nettype none

package ava_pkg;

  localparam logic [1:0] LS_IDLE = 2'b11;
  localparam logic [1:0] LS_RZ   = 2'b00;
  localparam logic [1:0] LS_ONE  = 2'b10;
  localparam logic [1:0] LS_ZERO = 2'b01;

  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_OVF   = 2'b10;
  localparam logic [1:0] ERR_TMO   = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    BIT   = 3'd2,
    GAP   = 3'd3,
    DRAIN = 3'd4
  } state_e;

  // A line state carries data when exactly one wire is high.
  function automatic logic is_data(input logic [1:0] ls);
    return ls[1] ^ ls[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/ava_rx_filter.sv
// ============================================================
// ava_rx_filter : 2-FF synchronizer plus DEGLITCH run-length filter
// Rev 1.0
// ============================================================
`default_nettype none

module ava_rx_filter
  import ava_pkg::*;
#(
  parameter int DEGLITCH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_p_i,
  input  logic       rx_m_i,
  output logic [1:0] ls_o,
  output logic       ls_chg_o
);

  localparam int RUN_W = $clog2(DEGLITCH + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEGLITCH);

  logic [1:0]       meta_q, sync_q, cand_q, ls_q;
  logic [RUN_W-1:0] run_q, run_d;
  logic             chg_q;

  // Length of the current run of identical synchronized samples, saturating.
  always_comb begin
    run_d = RUN_W'(1);
    if (sync_q == cand_q) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= LS_IDLE;
      sync_q <= LS_IDLE;
      cand_q <= LS_IDLE;
      ls_q   <= LS_IDLE;
      run_q  <= RUN_MAX;
      chg_q  <= 1'b0;
    end else begin
      meta_q <= {rx_p_i, rx_m_i};
      sync_q <= meta_q;
      cand_q <= sync_q;
      run_q  <= run_d;
      chg_q  <= 1'b0;
      if (run_d == RUN_MAX && sync_q != ls_q) begin
        ls_q  <= sync_q;
        chg_q <= 1'b1;
      end
    end
  end

  assign ls_o     = ls_q;
  assign ls_chg_o = chg_q;

endmodule

`default_nettype wire

// File: rtl/ava_rx.sv
// ============================================================
// ava_rx : four-state RZ line receiver, LSB-first frame assembly
// Rev 1.0
// ============================================================
`default_nettype none

module ava_rx
  import ava_pkg::*;
#(
  parameter int FRAME_BITS = 32,
  parameter int DEGLITCH   = 4,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 11
) (
  input  logic                  clk,
  input  logic                  global_reset_n,
  input  logic                  rx_p,
  input  logic                  rx_m,
  input  logic                  enable,
  output logic [FRAME_BITS-1:0] data,
  output logic                  data_valid,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic                  busy
);

  localparam int BC_W = $clog2(FRAME_BITS + 1);
  localparam logic [BC_W-1:0]  FULL     = BC_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0] ls;
  logic       ls_chg;

  state_e                state_q;
  logic [FRAME_BITS-1:0] sr_q, data_q;
  logic [BC_W-1:0]       bit_cnt_q;
  logic [CNT_W-1:0]      timer_q;
  logic                  valid_q, err_q, busy_q;
  logic [1:0]            err_code_q;

  ava_rx_filter #(
    .DEGLITCH (DEGLITCH)
  ) u_filter (
    .clk_i    (clk),
    .rst_ni   (global_reset_n),
    .rx_p_i   (rx_p),
    .rx_m_i   (rx_m),
    .ls_o     (ls),
    .ls_chg_o (ls_chg)
  );

  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      data_q     <= '0;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (state_q == IDLE) begin
        timer_q <= '0;
        if (enable && ls == LS_RZ) begin
          state_q   <= SYNC;
          bit_cnt_q <= '0;
          busy_q    <= 1'b1;
        end
      end else if (!enable) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else if (state_q == DRAIN) begin
        if (ls == LS_IDLE) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      end else if (ls == LS_IDLE) begin
        // SYNC has captured nothing, so returning to idle there is silent.
        state_q <= IDLE;
        busy_q  <= 1'b0;
        if (state_q != SYNC) begin
          if (bit_cnt_q == FULL) begin
            data_q  <= sr_q;
            valid_q <= 1'b1;
          end else begin
            err_q      <= 1'b1;
            err_code_q <= ERR_SHORT;
          end
        end
      end else if (ls_chg) begin
        timer_q <= '0;
        if (is_data(ls)) begin
          if (bit_cnt_q == FULL) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_OVF;
            state_q    <= DRAIN;
          end else begin
            sr_q      <= {ls[1], sr_q[FRAME_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            state_q   <= BIT;
          end
        end else if (state_q == BIT) begin
          state_q <= GAP;
        end
      end else if (timer_q == TMO_LAST) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_TMO;
        state_q    <= DRAIN;
      end else begin
        timer_q <= timer_q + 1'b1;
      end
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ava_rx.sv
// ============================================================
// tb_ava_rx : directed self-checking bench for ava_rx
// Rev 1.0
// ============================================================
`default_nettype none

module tb_ava_rx;

  logic        clk = 1'b0;
  logic        global_reset_n;
  logic        rx_p, rx_m, enable;
  logic [31:0] data;
  logic        data_valid, err, busy;
  logic [1:0]  err_code;

  ava_rx #(
    .FRAME_BITS (32),
    .DEGLITCH   (4),
    .TIMEOUT    (1024),
    .CNT_W      (11)
  ) dut (
    .clk            (clk),
    .global_reset_n (global_reset_n),
    .rx_p           (rx_p),
    .rx_m           (rx_m),
    .enable         (enable),
    .data           (data),
    .data_valid     (data_valid),
    .err            (err),
    .err_code       (err_code),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int   cyc = 0, n_valid = 0, n_err = 0, n_both = 0, err_cyc = 0, busy_cyc = 0;
  logic err_prev = 1'b0, busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (data_valid) n_valid <= n_valid + 1;
    if (err) n_err <= n_err + 1;
    if (data_valid && err) n_both <= n_both + 1;
    if (err && !err_prev) err_cyc <= cyc;
    if (busy && !busy_prev) busy_cyc <= cyc;
    err_prev  <= err;
    busy_prev <= busy;
  end

  int n_vec = 0, n_miss = 0;
  int b_valid, b_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [1:0] s, input int n);
    {rx_p, rx_m} = s;
    repeat (n) @(negedge clk);
  endtask

  // Each bit: 16 cycles of RZ then 16 cycles of data; glitch mode plants a
  // 2-cycle 11 or 10 pulse in the middle of every RZ gap.
  task automatic send_bits(input logic [63:0] val, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      if (glitch) begin
        hold(2'b00, 6);
        hold((i % 2 == 0) ? 2'b11 : 2'b10, 2);
        hold(2'b00, 8);
      end else begin
        hold(2'b00, 16);
      end
      hold(val[i] ? 2'b10 : 2'b01, 16);
    end
  endtask

  task automatic snap();
    b_valid = n_valid;
    b_err   = n_err;
  endtask

  initial begin
    global_reset_n = 1'b0;
    enable = 1'b1;
    rx_p = 1'b1;
    rx_m = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_data", data, 0);
    check("rst_valid", data_valid, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    check("rst_busy", busy, 0);
    global_reset_n = 1'b1;
    hold(2'b11, 10);

    // Full frame
    snap();
    hold(2'b00, 32);
    send_bits(64'hDEADBEEF, 32, 1'b0);
    hold(2'b11, 40);
    check("t1_data", data, 32'hDEADBEEF);
    check("t1_nvalid", n_valid - b_valid, 1);
    check("t1_nerr", n_err - b_err, 0);
    check("t1_busy", busy, 0);

    // Short frame
    snap();
    hold(2'b00, 32);
    send_bits(64'h000F0F0F, 20, 1'b0);
    hold(2'b11, 40);
    check("t2_nerr", n_err - b_err, 1);
    check("t2_code", err_code, 2'b01);
    check("t2_nvalid", n_valid - b_valid, 0);
    check("t2_data", data, 32'hDEADBEEF);
    check("t2_busy", busy, 0);

    // Overflow: 33 bits
    snap();
    hold(2'b00, 32);
    send_bits(64'h1_8000_0001, 33, 1'b0);
    check("t3_nerr", n_err - b_err, 1);
    check("t3_code", err_code, 2'b10);
    check("t3_busy_drain", busy, 1);
    hold(2'b11, 40);
    check("t3_nvalid", n_valid - b_valid, 0);
    check("t3_busy", busy, 0);
    check("t3_nerr_end", n_err - b_err, 1);

    // Timeout with the line stuck in RZ
    snap();
    hold(2'b00, 2000);
    check("t4_nerr", n_err - b_err, 1);
    check("t4_code", err_code, 2'b11);
    check("t4_latency", err_cyc - busy_cyc, 1024);
    check("t4_busy_held", busy, 1);
    hold(2'b11, 40);
    check("t4_busy", busy, 0);
    check("t4_nvalid", n_valid - b_valid, 0);

    // Enable dropped mid-frame
    snap();
    hold(2'b00, 32);
    send_bits(64'h5A, 8, 1'b0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("en_busy", busy, 0);
    hold(2'b11, 20);
    enable = 1'b1;
    hold(2'b11, 5);
    check("en_nvalid", n_valid - b_valid, 0);
    check("en_nerr", n_err - b_err, 0);
    check("en_data", data, 32'hDEADBEEF);

    // Glitches in every RZ gap
    snap();
    hold(2'b00, 32);
    send_bits(64'h12345678, 32, 1'b1);
    hold(2'b11, 40);
    check("t5_data", data, 32'h12345678);
    check("t5_nvalid", n_valid - b_valid, 1);
    check("t5_nerr", n_err - b_err, 0);

    // Asynchronous reset mid-frame
    hold(2'b00, 32);
    send_bits(64'hA5A5A5A5, 10, 1'b0);
    #3;
    global_reset_n = 1'b0;
    #1;
    check("t6_data", data, 0);
    check("t6_busy", busy, 0);
    check("t6_code", err_code, 0);
    check("t6_valid", data_valid, 0);
    check("t6_err", err, 0);
    @(negedge clk);
    global_reset_n = 1'b1;
    hold(2'b11, 20);
    snap();
    hold(2'b00, 32);
    send_bits(64'hA5A5A5A5, 32, 1'b0);
    hold(2'b11, 40);
    check("t6_frame", data, 32'hA5A5A5A5);
    check("t6_nvalid", n_valid - b_valid, 1);
    check("t6_nerr", n_err - b_err, 0);

    check("never_both", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
